// File: rtl/stream_sink_pkg.sv
// stream_sink_pkg: shared state encoding, count width and fold/signature helpers for kernel_stream_sink
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif
package stream_sink_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, REPORT} state_t;
    localparam int CNT_W = 16;
    localparam int FOLD_W = 1024;
    // Zero padding up to FOLD_W leaves the byte XOR unchanged, so any word width up to FOLD_W works.
    function automatic logic [7:0] fold_bytes(input logic [FOLD_W-1:0] w);
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < FOLD_W / 8; i++) x ^= w[i*8 +: 8];
        return x;
    endfunction
    function automatic logic [31:0] sig_step(input logic [31:0] sig, input logic [31:0] w);
        return {sig[30:0], sig[31]} ^ w;
    endfunction
endpackage

// File: rtl/sink_fifo.sv
// sink_fifo: DEPTH x DATA_WIDTH synchronous FIFO with registered occupancy and full/empty flags
module sink_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);
    localparam int AW = `CLOG2(DEPTH);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0] count;
    always_ff @(posedge ap_clk)
        if (push) mem[wptr] <= din;
    always_ff @(posedge ap_clk or posedge ap_rst)
        if (ap_rst) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            wptr <= push ? wptr + 1'b1 : wptr;
            rptr <= pop ? rptr + 1'b1 : rptr;
            count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
        end
    always_comb begin
        full = count == (AW+1)'(DEPTH);
        empty = count == '0;
        dout = mem[rptr];
    end
endmodule

// File: rtl/kernel_stream_sink.sv
// kernel_stream_sink: ap_fifo sink with rate-limited drain, nibble fold to pins and a per-run signature/count report
module kernel_stream_sink
    import stream_sink_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int EXP_COUNT = 64,
    parameter int DRAIN_INV = 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    input  logic                  ap_done,
    input  logic [DATA_WIDTH-1:0] fifo_din,
    input  logic                  fifo_write,
    output logic                  fifo_full_n,
    output logic [3:0]            data_out,
    output logic                  data_valid,
    output logic [31:0]           sig_out,
    output logic                  sig_valid,
    output logic                  count_err
);
    localparam int DCW = DRAIN_INV > 1 ? `CLOG2(DRAIN_INV) : 1;
    state_t state, state_nx;
    logic [DATA_WIDTH-1:0] head;
    logic full, empty, active, push, pop, drained, ovf, s1_v;
    logic [7:0] s1_x;
    logic [DCW-1:0] dcnt;
    logic [CNT_W-1:0] cnt;
    logic [31:0] sig;
    sink_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
        .ap_clk(ap_clk),
        .ap_rst(ap_rst),
        .push(push),
        .pop(pop),
        .din(fifo_din),
        .dout(head),
        .full(full),
        .empty(empty)
    );
    always_comb begin
        active = state == RUN || state == FLUSH;
        fifo_full_n = active && !full;
        push = fifo_write && fifo_full_n;
        pop = active && dcnt == '0 && !empty;
        drained = empty && !s1_v && !data_valid;
        state_nx = state == IDLE ? (ap_start ? RUN : IDLE) :
                   state == RUN ? (ap_done ? FLUSH : RUN) :
                   state == FLUSH ? (drained ? REPORT : FLUSH) : IDLE;
        sig_valid = state == REPORT;
        count_err = sig_valid && (cnt != CNT_W'(EXP_COUNT) || ovf);
        sig_out = sig;
    end
    always_ff @(posedge ap_clk or posedge ap_rst)
        if (ap_rst) state <= IDLE;
        else state <= state_nx;
    always_ff @(posedge ap_clk or posedge ap_rst)
        if (ap_rst) begin
            sig <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            dcnt <= '0;
            s1_v <= 1'b0;
            s1_x <= '0;
            data_valid <= 1'b0;
            data_out <= '0;
        end else begin
            if (state == IDLE && ap_start) begin
                sig <= '0;
                cnt <= '0;
                ovf <= 1'b0;
                dcnt <= '0;
            end else if (active) begin
                // An empty FIFO at a drain slot still advances the counter; that slot is lost.
                dcnt <= dcnt == DCW'(DRAIN_INV - 1) ? '0 : dcnt + 1'b1;
                ovf <= ovf || (fifo_write && !fifo_full_n);
                if (pop) begin
                    sig <= sig_step(sig, 32'(head));
                    cnt <= cnt == '1 ? cnt : cnt + 1'b1;
                end
            end
            s1_v <= pop;
            s1_x <= fold_bytes(FOLD_W'(head));
            data_valid <= s1_v;
            data_out <= s1_v ? s1_x[7:4] ^ s1_x[3:0] : 4'h0;
        end
endmodule

// File: tb/tb_kernel_stream_sink.sv
// tb_kernel_stream_sink: three sinks (fast drain, backpressure, stalled drain) checked every cycle against a queue-based model
module tb_kernel_stream_sink;
    localparam int NI = 3;
    localparam int DEP = 16;
    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    logic st [NI];
    logic dn [NI];
    logic wr [NI];
    logic [31:0] din [NI];
    logic fn [NI];
    logic [3:0] dout [NI];
    logic dv [NI];
    logic [31:0] sg [NI];
    logic sv [NI];
    logic ce [NI];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ph [NI];
    int t0 [NI];
    int mcnt [NI];
    int ndv [NI];
    int last_dv [NI];
    logic [31:0] msig [NI];
    bit movf [NI];
    bit acc [NI];
    logic [31:0] fq [NI][$];
    int dq [NI][$];
    logic [3:0] nq [NI][$];

    always #5 ap_clk = ~ap_clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        kernel_stream_sink #(
            .DATA_WIDTH(32),
            .DEPTH(DEP),
            .EXP_COUNT(g == 0 ? 64 : g == 1 ? 40 : 2),
            .DRAIN_INV(g == 0 ? 1 : g == 1 ? 4 : 64)
        ) u_dut (
            .ap_clk(ap_clk),
            .ap_rst(ap_rst),
            .ap_start(st[g]),
            .ap_done(dn[g]),
            .fifo_din(din[g]),
            .fifo_write(wr[g]),
            .fifo_full_n(fn[g]),
            .data_out(dout[g]),
            .data_valid(dv[g]),
            .sig_out(sg[g]),
            .sig_valid(sv[g]),
            .count_err(ce[g])
        );
    end

    function automatic int dinv(input int i);
        return i == 0 ? 1 : i == 1 ? 4 : 64;
    endfunction

    function automatic int expc(input int i);
        return i == 0 ? 64 : i == 1 ? 40 : 2;
    endfunction

    function automatic logic [3:0] nib(input logic [31:0] w);
        logic [7:0] x;
        x = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        return x[7:4] ^ x[3:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input int i, input logic efn, input logic edv, input logic [3:0] edo,
                            input logic [31:0] esg, input logic esv, input logic ece);
        chk($sformatf("full_n[%0d]@%0d", i, cyc), 32'(fn[i]), 32'(efn));
        chk($sformatf("data_valid[%0d]@%0d", i, cyc), 32'(dv[i]), 32'(edv));
        chk($sformatf("data_out[%0d]@%0d", i, cyc), 32'(dout[i]), 32'(edo));
        chk($sformatf("sig_out[%0d]@%0d", i, cyc), sg[i], esg);
        chk($sformatf("sig_valid[%0d]@%0d", i, cyc), 32'(sv[i]), 32'(esv));
        chk($sformatf("count_err[%0d]@%0d", i, cyc), 32'(ce[i]), 32'(ece));
    endtask

    task automatic step_model(input int i);
        logic act, efn, edv, pop, drained;
        logic [31:0] w;
        if (ap_rst) begin
            chk_outs(i, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
            ph[i] = 0;
            fq[i].delete();
            dq[i].delete();
            nq[i].delete();
            msig[i] = 32'h0;
            mcnt[i] = 0;
            movf[i] = 1'b0;
            acc[i] = 1'b0;
        end else begin
            act = ph[i] == 1 || ph[i] == 2;
            efn = act && fq[i].size() != DEP;
            edv = dq[i].size() > 0 && dq[i][0] == cyc;
            chk_outs(i, efn, edv, edv ? nq[i][0] : 4'h0, msig[i], ph[i] == 3,
                     ph[i] == 3 && (mcnt[i] != expc(i) || movf[i]));
            if (edv) begin
                void'(dq[i].pop_front());
                void'(nq[i].pop_front());
                ndv[i]++;
                last_dv[i] = cyc;
            end
            drained = ph[i] == 2 && fq[i].size() == 0 && !edv && dq[i].size() == 0;
            pop = act && (cyc - t0[i]) % dinv(i) == 0 && fq[i].size() > 0;
            acc[i] = wr[i] && efn;
            if (act && wr[i] && !efn) movf[i] = 1'b1;
            if (pop) begin
                w = fq[i].pop_front();
                dq[i].push_back(cyc + 2);
                nq[i].push_back(nib(w));
                msig[i] = {msig[i][30:0], msig[i][31]} ^ w;
                if (mcnt[i] < 65535) mcnt[i]++;
            end
            if (acc[i]) fq[i].push_back(din[i]);
            case (ph[i])
                0: if (st[i]) begin
                    ph[i] = 1;
                    t0[i] = cyc + 1;
                    msig[i] = 32'h0;
                    mcnt[i] = 0;
                    movf[i] = 1'b0;
                    ndv[i] = 0;
                end
                1: if (dn[i]) ph[i] = 2;
                2: if (drained) ph[i] = 3;
                default: ph[i] = 0;
            endcase
        end
    endtask

    task automatic tick();
        @(negedge ap_clk);
        for (int i = 0; i < NI; i++) step_model(i);
        @(posedge ap_clk);
        #1;
        cyc++;
    endtask

    task automatic wait_report(input int i, input int budget);
        int n;
        n = 0;
        while (!sv[i] && n < budget) begin
            tick();
            n++;
        end
        chk($sformatf("report_seen[%0d]", i), 32'(sv[i]), 32'd1);
    endtask

    initial begin
        int n, nb;
        bit saw;
        for (int i = 0; i < NI; i++) begin
            st[i] = 1'b0;
            dn[i] = 1'b0;
            wr[i] = 1'b0;
            din[i] = 32'h0;
        end
        tick();
        tick();
        chk("reset_full_n", 32'(fn[1]), 32'd0);
        ap_rst = 1'b0;
        tick();
        // Writes and done in IDLE must be ignored.
        wr[0] = 1'b1;
        din[0] = 32'hdead_beef;
        dn[0] = 1'b1;
        tick();
        tick();
        wr[0] = 1'b0;
        dn[0] = 1'b0;
        tick();
        chk("idle_no_report", 32'(sv[0]), 32'd0);
        // Basic run: ap_start held high through ap_done, which wins.
        st[0] = 1'b1;
        tick();
        chk("run_full_n", 32'(fn[0]), 32'd1);
        for (int w = 0; w < 64; w++) begin
            wr[0] = 1'b1;
            din[0] = 32'(w);
            tick();
        end
        wr[0] = 1'b0;
        dn[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        dn[0] = 1'b0;
        wait_report(0, 100);
        chk("basic_count_err", 32'(ce[0]), 32'd0);
        chk("basic_pulses", 32'(ndv[0]), 32'd64);
        tick();
        // Fold latency and random-gap run.
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        wr[0] = 1'b1;
        din[0] = 32'h1234_5678;
        tick();
        wr[0] = 1'b0;
        tick();
        tick();
        chk("fold_valid", 32'(dv[0]), 32'd1);
        chk("fold_nibble", 32'(dout[0]), 32'h8);
        for (int w = 0; w < 63;) begin
            wr[0] = $urandom_range(0, 2) != 0;
            din[0] = $urandom;
            if (wr[0]) w++;
            tick();
        end
        wr[0] = 1'b0;
        dn[0] = 1'b1;
        tick();
        dn[0] = 1'b0;
        wait_report(0, 100);
        chk("random_count_err", 32'(ce[0]), 32'd0);
        chk("random_pulses", 32'(ndv[0]), 32'd64);
        tick();
        // Short run, ap_done while a word is still buffered.
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        for (int w = 0; w < 63; w++) begin
            wr[0] = 1'b1;
            din[0] = $urandom;
            tick();
        end
        wr[0] = 1'b0;
        dn[0] = 1'b1;
        tick();
        dn[0] = 1'b0;
        wait_report(0, 100);
        chk("short_count_err", 32'(ce[0]), 32'd1);
        chk("short_pulses", 32'(ndv[0]), 32'd63);
        chk("short_dv_before_report", 32'(last_dv[0] < cyc), 32'd1);
        tick();
        // Signature with two words, then a single word.
        st[2] = 1'b1;
        tick();
        st[2] = 1'b0;
        wr[2] = 1'b1;
        din[2] = 32'h1;
        tick();
        tick();
        wr[2] = 1'b0;
        dn[2] = 1'b1;
        tick();
        dn[2] = 1'b0;
        wait_report(2, 400);
        chk("sig_two", sg[2], 32'h3);
        chk("sig_two_err", 32'(ce[2]), 32'd0);
        tick();
        st[2] = 1'b1;
        tick();
        st[2] = 1'b0;
        wr[2] = 1'b1;
        din[2] = 32'h1;
        tick();
        wr[2] = 1'b0;
        dn[2] = 1'b1;
        tick();
        dn[2] = 1'b0;
        wait_report(2, 400);
        chk("sig_one", sg[2], 32'h1);
        chk("sig_one_err", 32'(ce[2]), 32'd1);
        tick();
        // Overflow: fill with drain stalled, then one write too many.
        st[2] = 1'b1;
        tick();
        st[2] = 1'b0;
        for (int w = 0; w < DEP; w++) begin
            wr[2] = 1'b1;
            din[2] = $urandom;
            tick();
        end
        chk("ovf_full_n_low", 32'(fn[2]), 32'd0);
        din[2] = 32'hbad0_bad0;
        tick();
        wr[2] = 1'b0;
        dn[2] = 1'b1;
        tick();
        dn[2] = 1'b0;
        wait_report(2, DEP * 64 + 200);
        chk("ovf_count_err", 32'(ce[2]), 32'd1);
        chk("ovf_pulses", 32'(ndv[2]), 32'(DEP));
        tick();
        // Async reset mid-run with five words buffered and one word in the output stage.
        st[1] = 1'b1;
        tick();
        st[1] = 1'b0;
        for (int w = 0; w < 6; w++) begin
            wr[1] = 1'b1;
            din[1] = $urandom;
            tick();
        end
        wr[1] = 1'b0;
        chk("pre_rst_dv", 32'(dv[1]), 32'd1);
        ap_rst = 1'b1;
        #1;
        chk("rst_full_n", 32'(fn[1]), 32'd0);
        chk("rst_dv", 32'(dv[1]), 32'd0);
        chk("rst_dout", 32'(dout[1]), 32'd0);
        chk("rst_sig", sg[1], 32'h0);
        chk("rst_sv", 32'(sv[1]), 32'd0);
        chk("rst_ce", 32'(ce[1]), 32'd0);
        tick();
        tick();
        ap_rst = 1'b0;
        tick();
        // Backpressure: kernel writes whenever full_n is high.
        st[1] = 1'b1;
        tick();
        st[1] = 1'b0;
        chk("post_rst_sig", sg[1], 32'h0);
        chk("post_rst_full_n", 32'(fn[1]), 32'd1);
        n = 0;
        nb = 0;
        saw = 1'b0;
        while (n < 40 && nb < 2000) begin
            wr[1] = fn[1];
            din[1] = $urandom;
            if (!fn[1]) saw = 1'b1;
            tick();
            if (acc[1]) n++;
            nb++;
        end
        wr[1] = 1'b0;
        chk("bp_accepted", 32'(n), 32'd40);
        chk("bp_saw_full", 32'(saw), 32'd1);
        dn[1] = 1'b1;
        tick();
        dn[1] = 1'b0;
        wait_report(1, 400);
        chk("bp_count_err", 32'(ce[1]), 32'd0);
        chk("bp_pulses", 32'(ndv[1]), 32'd40);
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/kernel_stream_sink.md
# kernel_stream_sink

Receiver for an HLS kernel's `ap_fifo` output stream (`*_din` / `*_full_n` / `*_write`); it replaces the hard-tied `full_n = 1` in benchmark wrappers. It buffers kernel output words in a small FIFO and drains them at a programmable rate, which exercises real backpressure. Drained words are folded to a 4-bit `data_out`/`data_valid` pair for the board pins, and accumulated into a per-run signature and word count. After `ap_done`, the block emits a one-cycle report with the signature and an error flag.

## Interface
- `DATA_WIDTH`, 32, kernel stream word width (multiple of 8)
- `DEPTH`, 16, FIFO depth in words (power of 2, ≥2)
- `EXP_COUNT`, 64, expected words per kernel run
- `DRAIN_INV`, 1, one pop attempt every `DRAIN_INV` cycles (≥1)

Ports:
- `ap_clk` in 1: sole clock
- `ap_rst` in 1: asynchronous, active-high reset
- `ap_start` in 1: kernel start level, as driven to the kernel
- `ap_done` in 1: kernel done pulse
- `fifo_din` in `DATA_WIDTH`: kernel stream data
- `fifo_write` in 1: kernel write strobe
- `fifo_full_n` out 1: not-full, to kernel `*_full_n`
- `data_out` out 4: folded nibble of the drained word
- `data_valid` out 1: `data_out` is valid
- `sig_out` out 32: run signature, valid with `sig_valid`
- `sig_valid` out 1: one-cycle report strobe
- `count_err` out 1: report flag, valid with `sig_valid`

## Operation
- **States:** IDLE, RUN, FLUSH, REPORT.
  - IDLE→RUN when `ap_start`=1. On entry, clear signature, word count, overflow flag and drain counter.
  - RUN→FLUSH when `ap_done`=1. `ap_done` takes priority over `ap_start` in the same cycle. `ap_done` in IDLE is ignored.
  - FLUSH→REPORT when the FIFO is empty and the output pipe is empty.
  - REPORT→IDLE unconditionally after 1 cycle.
- **Accept:** `fifo_full_n` = (state is RUN or FLUSH) and (occupancy ≠ `DEPTH`).
  - A push happens when `fifo_write && fifo_full_n`.
  - A write while `fifo_full_n`=0 in RUN/FLUSH is dropped and sets the sticky `ovf` flag.
  - A write in IDLE/REPORT is dropped silently.
- **Drain:** a modulo-`DRAIN_INV` counter runs in RUN/FLUSH. A pop happens when the counter is 0 and the FIFO is non-empty.
  - If the FIFO is empty when the counter is 0, the counter still advances. The slot is lost.
- **Fold:** stage 1 registers `x` = XOR of all bytes of the popped word. Stage 2 registers `data_out = x[7:4]^x[3:0]` and `data_valid`=1. When not valid, `data_out` = 0.
- **Signature (per pop):** `sig <= {sig[30:0],sig[31]} ^ word[31:0]`. Words narrower than 32 bits are zero-extended.
- **Count:** the word count is 16 bits, saturating at 0xFFFF, and increments per pop.
- **Report:** `sig_valid`=1 and `sig_out`=sig. `count_err` = (count ≠ `EXP_COUNT`) | `ovf`.
- **Reset mid-operation:** FIFO emptied, state IDLE, no report.

## Timing
- **Reset values:** all outputs are 0, including `fifo_full_n`=0 (state IDLE).
- **Occupancy:** registered. A push at cycle t is visible in `fifo_full_n` at t+1. A push and a pop in the same cycle leave occupancy unchanged.
- When full, a same-cycle pop does not enable a push: `fifo_full_n` is already 0.
- **Latency:** push at t → earliest pop at t+1 → `data_valid` at t+3 (`DRAIN_INV`=1). Signature and count update at pop+1.
- **Ordering:** strict FIFO order, no loss while `fifo_full_n`=1.
- `sig_valid` / `count_err` rise 1 cycle after the FLUSH exit condition and last exactly 1 cycle. `sig_out` holds its value until the next RUN entry.

## Structure
- **Shared package `stream_sink_pkg`:**
  - state enum
  - `fold_bytes` function (byte XOR)
  - `sig_step` function
  - 16-bit count width constant
- Use the existing `CLOG2` macro for pointer and occupancy widths.
- **Sub-module `sink_fifo`:** synchronous, `DEPTH`×`DATA_WIDTH`, with push/pop, registered occupancy, full/empty. The FSM, drain counter, fold pipe and signature live in the top.

## Test plan
- **Basic run:** `DRAIN_INV`=1. `ap_start`, then words 0..63 on consecutive cycles, then `ap_done`. Expect 64 `data_valid` pulses in order; report with `count_err`=0. A word 0x12345678 gives `data_out`=0x8.
- **Signature:** `EXP_COUNT`=2, words 0x00000001, 0x00000001 → `sig_out`=0x00000003, `count_err`=0. A single word gives `sig_out`=0x00000001 and `count_err`=1.
- **Backpressure:** `DRAIN_INV`=4, kernel writes whenever `fifo_full_n`=1, 40 words. Expect `fifo_full_n` low exactly while occupancy=16, no drops, all 40 out in order, `count_err` per `EXP_COUNT`=40 → 0.
- **Overflow:** fill to 16 with drain stalled (`DRAIN_INV`=64), then assert `fifo_write` once more → word absent from output, report `count_err`=1.
- **Short run:** 63 words with `EXP_COUNT`=64 → `count_err`=1. `ap_done` while words are still buffered → report only after the last `data_valid`.
- **Async reset:** assert `ap_rst` mid-RUN with 5 words buffered → all outputs 0 within the same cycle, no `sig_valid`. The next run starts with an empty FIFO and sig=0.
